// File: rtl/ifetch.sv
// ifetch: instruction fetch unit with a 4-entry halfword prefetch FIFO.
// Word-aligned 32-bit reads are split into 16-bit parcels. Each parcel is
// queued with its PC and a fault flag, then handed to decode one parcel per
// idone pulse. Redirects flush the stream. A bus fault queues a fault token
// and halts fetching until the next redirect.
module ifetch #(
   parameter int unsigned   RV        = 32,
   parameter logic [RV-1:0] RESET_VEC = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pc_load,
   input  logic [RV-1:0] pc_new,
   input  logic          stall,
   output logic          mem_req,
   output logic [RV-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [31:0]   mem_data,
   input  logic          mem_fault,
   output logic [15:0]   ins,
   output logic [RV-1:0] ins_pc,
   output logic          ins_fault,
   output logic          idone
);

   typedef struct packed {
      logic [15:0]   parcel;
      logic [RV-1:0] pc;
      logic          fault;
   } entry_t;

   localparam logic [RV-1:0] RESET_WORD = {RESET_VEC[RV-1:2], 2'b00};

   // Fetch-side state
   logic [RV-1:0] r_faddr;
   logic          r_skip_lo;
   logic          r_discard;
   logic          r_halted;
   logic          r_mem_req;
   logic [RV-1:0] r_mem_addr;

   // Prefetch FIFO
   entry_t        r_fifo [4];
   logic [1:0]    r_rd;
   logic [1:0]    r_wr;
   logic [2:0]    r_count;

   // Decode-side output registers
   logic [15:0]   r_ins;
   logic [RV-1:0] r_ins_pc;
   logic          r_ins_fault;
   logic          r_idone;

   logic          w_ack;
   logic          w_take;
   logic          w_pop;
   logic          w_issue;
   logic [RV-1:0] w_cur_pc;
   logic [RV-1:0] w_new_word;
   logic [1:0]    w_wr_next;
   logic [1:0]    w_push_n;
   entry_t        w_entry0;
   entry_t        w_entry1;
   logic          w_unused;

   // Bit 0 of a redirect target has no meaning for halfword-aligned code.
   assign w_unused   = pc_new[0];

   assign w_ack      = r_mem_req & mem_ack;
   // Only an ack that belongs to the live stream delivers anything. A
   // redirect in the same cycle kills the ack along with the stream.
   assign w_take     = w_ack & ~r_discard & ~pc_load;
   assign w_pop      = (r_count != 3'd0) & ~stall & ~pc_load;
   assign w_issue    = ~r_mem_req & ~r_halted & (r_count <= 3'd2) & ~pc_load;
   assign w_cur_pc   = {r_faddr[RV-1:2], r_skip_lo, 1'b0};
   assign w_new_word = {pc_new[RV-1:2], 2'b00};
   assign w_wr_next  = r_wr + 2'd1;

   // Build up to two FIFO entries from the returning word, low half first
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can leave one unassigned and infer a latch.
      w_push_n = 2'd0;
      w_entry0 = '0;
      w_entry1 = '0;
      if (w_take && mem_fault) begin
         w_push_n = 2'd1;
         w_entry0 = entry_t'{parcel: 16'h0000, pc: w_cur_pc, fault: 1'b1};
      end else if (w_take && r_skip_lo) begin
         w_push_n = 2'd1;
         w_entry0 = entry_t'{parcel: mem_data[31:16],
                             pc: {r_faddr[RV-1:2], 2'b10}, fault: 1'b0};
      end else if (w_take) begin
         w_push_n = 2'd2;
         w_entry0 = entry_t'{parcel: mem_data[15:0],
                             pc: {r_faddr[RV-1:2], 2'b00}, fault: 1'b0};
         w_entry1 = entry_t'{parcel: mem_data[31:16],
                             pc: {r_faddr[RV-1:2], 2'b10}, fault: 1'b0};
      end
   end

   // FIFO storage writes; occupancy is tracked separately by count/pointers
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; r_count decides which entries are valid, so resetting the data would only add logic.
      if (w_push_n != 2'd0) begin
         r_fifo[r_wr] <= w_entry0;
      end
      if (w_push_n == 2'd2) begin
         r_fifo[w_wr_next] <= w_entry1;
      end
   end

   // Request sequencing, redirect handling, FIFO bookkeeping and delivery
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: state registers use non-blocking assignments so every register samples pre-edge values, whatever the statement order.
         r_faddr     <= RESET_WORD;
         r_skip_lo   <= RESET_VEC[1];
         r_discard   <= 1'b0;
         r_halted    <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_rd        <= 2'd0;
         r_wr        <= 2'd0;
         r_count     <= 3'd0;
         r_ins       <= 16'h0000;
         r_ins_pc    <= RESET_VEC;
         r_ins_fault <= 1'b0;
         r_idone     <= 1'b0;
      end else begin
         // Delivery: the head moves to the output registers. Otherwise the outputs hold.
         r_idone <= w_pop;
         if (w_pop) begin
            r_ins       <= r_fifo[r_rd].parcel;
            r_ins_pc    <= r_fifo[r_rd].pc;
            r_ins_fault <= r_fifo[r_rd].fault;
         end

         if (pc_load) begin
            r_rd    <= 2'd0;
            r_wr    <= 2'd0;
            r_count <= 3'd0;
         end else begin
            r_rd    <= r_rd + {1'b0, w_pop};
            r_wr    <= r_wr + w_push_n;
            r_count <= r_count + {1'b0, w_push_n} - {2'b00, w_pop};
         end

         if (pc_load) begin
            r_faddr   <= w_new_word;
            r_skip_lo <= pc_new[1];
            r_halted  <= 1'b0;
            if (r_mem_req && !mem_ack) begin
               // The old request is still in flight: hold it and drop its data later.
               r_discard <= 1'b1;
            end else begin
               // The bus is free (idle, or its ack is dropped now): fetch the target at once.
               r_discard  <= 1'b0;
               r_mem_req  <= 1'b1;
               r_mem_addr <= w_new_word;
            end
         end else if (w_ack) begin
            r_mem_req <= 1'b0;
            r_discard <= 1'b0;
            if (!r_discard) begin
               if (mem_fault) begin
                  r_halted <= 1'b1;
               end else begin
                  r_faddr   <= r_faddr + RV'(4);
                  r_skip_lo <= 1'b0;
               end
            end
         end else if (w_issue) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_faddr;
         end
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_addr  = r_mem_addr;
   assign ins       = r_ins;
   assign ins_pc    = r_ins_pc;
   assign ins_fault = r_ins_fault;
   assign idone     = r_idone;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch with a parcel-stream reference model.
// The memory returns an address-derived pattern. The model predicts every
// delivered parcel from the redirect history, and directed steps pin key values.
module tb_ifetch;

   localparam int          RV   = 32;
   localparam logic [31:0] RVEC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pc_load = 1'b0;
   logic [31:0] pc_new = 32'h0;
   logic        stall = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_data = 32'h0;
   logic        mem_fault = 1'b0;
   logic [15:0] ins;
   logic [31:0] ins_pc;
   logic        ins_fault;
   logic        idone;

   int          n_checks = 0;
   int          n_fail = 0;
   int          mem_wait = 0;
   logic        fault_en = 1'b0;
   logic [31:0] fault_addr = 32'h0000_0300;

   always #5 clk = ~clk;

   ifetch #(.RV(RV), .RESET_VEC(RVEC)) dut (
      .clk       (clk),
      .reset     (reset),
      .pc_load   (pc_load),
      .pc_new    (pc_new),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_data  (mem_data),
      .mem_fault (mem_fault),
      .ins       (ins),
      .ins_pc    (ins_pc),
      .ins_fault (ins_fault),
      .idone     (idone)
   );

   // Memory image: halfword at any address, 0xAAAA/0xBBBB in the word at 0x100
   function automatic logic [15:0] half_at(input logic [31:0] a);
      if (a[31:2] == 30'h40) return a[1] ? 16'hBBBB : 16'hAAAA;
      return a[15:0] ^ 16'hC3A5;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idone(input string name);
      int n;
      n = 0;
      while (!idone && n < 40) begin
         tick();
         n++;
      end
      check({name, "_idone_seen"}, 32'(idone), 32'd1);
   endtask

   task automatic wait_req_rise(input string name);
      int n;
      n = 0;
      while (mem_req && n < 40) begin
         tick();
         n++;
      end
      while (!mem_req && n < 80) begin
         tick();
         n++;
      end
      check({name, "_req_seen"}, 32'(mem_req), 32'd1);
   endtask

   task automatic fill_idle();
      stall = 1'b1;
      repeat (8) tick();
   endtask

   // Memory responder: acks after mem_wait extra cycles, data from half_at
   initial begin : responder
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_fault = 1'b0;
         if (mem_req) begin
            if (cnt >= mem_wait) begin
               mem_ack   = 1'b1;
               mem_data  = {half_at(mem_addr | 32'h2), half_at(mem_addr)};
               mem_fault = fault_en && (mem_addr[31:2] == fault_addr[31:2]);
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Reference model: the next parcel is always the one at m_pc, m_pc moves by 2
   logic [31:0] m_pc = RVEC;
   logic        m_halted = 1'b0;
   logic        flt_done = 1'b0;
   logic [15:0] last_ins = 16'h0;
   logic [31:0] last_pc = RVEC;
   logic        last_flt = 1'b0;
   logic        prev_block = 1'b0;
   logic        req_prev = 1'b0;
   logic        ack_prev = 1'b0;
   logic        rst_prev = 1'b1;
   logic        e_flt;
   logic [15:0] e_ins;

   initial begin : scoreboard
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (rst_prev) begin
            m_pc = RVEC; m_halted = 1'b0; flt_done = 1'b0;
            last_ins = 16'h0; last_pc = RVEC; last_flt = 1'b0;
            check("rst_mem_req", 32'(mem_req), 32'd0);
            check("rst_mem_addr", mem_addr, 32'd0);
         end
         if (idone) begin
            if (rst_prev || prev_block || flt_done) begin
               check("idone_unexpected", 32'(idone), 32'd0);
            end else begin
               e_flt = fault_en && (m_pc[31:2] == fault_addr[31:2]);
               e_ins = e_flt ? 16'h0000 : half_at(m_pc);
               check("ins", 32'(ins), 32'(e_ins));
               check("ins_pc", ins_pc, m_pc);
               check("ins_fault", 32'(ins_fault), 32'(e_flt));
               last_ins = e_ins; last_pc = m_pc; last_flt = e_flt;
               if (e_flt) flt_done = 1'b1;
               else m_pc = m_pc + 32'd2;
            end
         end else begin
            check("hold_ins", 32'(ins), 32'(last_ins));
            check("hold_ins_pc", ins_pc, last_pc);
            check("hold_ins_fault", 32'(ins_fault), 32'(last_flt));
         end
         if (mem_req) check("mem_addr_align", 32'(mem_addr[1:0]), 32'd0);
         if (m_halted) check("halted_no_req", 32'(mem_req), 32'd0);
         if (req_prev && !ack_prev && !rst_prev) check("req_hold", 32'(mem_req), 32'd1);

         if (mem_req && mem_ack && mem_fault && !pc_load) m_halted = 1'b1;
         if (pc_load) begin
            m_pc = pc_new & ~32'h1; m_halted = 1'b0; flt_done = 1'b0;
         end
         prev_block = stall | pc_load;
         req_prev   = mem_req;
         ack_prev   = mem_ack;
         rst_prev   = reset;
      end
   end

   // Directed sequence
   initial begin : stimulus
      repeat (3) tick();
      reset = 1'b0;
      check("reset_req_low", 32'(mem_req), 32'd0);
      tick();
      check("first_req", 32'(mem_req), 32'd1);
      check("first_addr", mem_addr, 32'h0000_0100);
      tick();
      check("first_idone_latency", 32'(idone), 32'd0);
      tick();
      check("p0_idone", 32'(idone), 32'd1);
      check("p0_ins", 32'(ins), 32'h0000_AAAA);
      check("p0_pc", ins_pc, 32'h0000_0100);
      tick();
      check("p1_idone", 32'(idone), 32'd1);
      check("p1_ins", 32'(ins), 32'h0000_BBBB);
      check("p1_pc", ins_pc, 32'h0000_0102);

      // Stall long enough to fill the FIFO, then drain four in a row
      repeat (6) tick();
      stall = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i >= 5) check("stall_no_req", 32'(mem_req), 32'd0);
      end
      stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("drain_idone", 32'(idone), 32'd1);
      end

      // Unaligned redirect from an idle bus
      fill_idle();
      pc_load = 1'b1; pc_new = 32'h0000_0206;
      tick();
      pc_load = 1'b0; stall = 1'b0;
      check("unal_req", 32'(mem_req), 32'd1);
      check("unal_addr", mem_addr, 32'h0000_0204);
      wait_req_rise("unal_next");
      check("unal_next_addr", mem_addr, 32'h0000_0208);
      wait_idone("unal");
      check("unal_pc", ins_pc, 32'h0000_0206);
      check("unal_ins", 32'(ins), 32'h0000_C1A3);

      // Flush while a slow request is outstanding
      fill_idle();
      mem_wait = 3;
      pc_load = 1'b1; pc_new = 32'h0000_0500;
      tick();
      check("flush_old_req", mem_addr, 32'h0000_0500);
      pc_new = 32'h0000_0400;
      tick();
      pc_load = 1'b0; stall = 1'b0;
      wait_req_rise("flush_new");
      check("flush_new_addr", mem_addr, 32'h0000_0400);
      wait_idone("flush");
      check("flush_pc", ins_pc, 32'h0000_0400);
      check("flush_ins", 32'(ins), 32'h0000_C7A5);
      mem_wait = 0;

      // Bus fault halts fetching until the next redirect
      fill_idle();
      fault_en = 1'b1;
      pc_load = 1'b1; pc_new = 32'h0000_0300; stall = 1'b0;
      tick();
      pc_load = 1'b0;
      check("fault_addr", mem_addr, 32'h0000_0300);
      wait_idone("fault");
      check("fault_flag", 32'(ins_fault), 32'd1);
      check("fault_ins", 32'(ins), 32'd0);
      check("fault_pc", ins_pc, 32'h0000_0300);
      repeat (8) begin
         tick();
         check("fault_halted_req", 32'(mem_req), 32'd0);
      end
      pc_load = 1'b1; pc_new = 32'h0000_0600; fault_en = 1'b0;
      tick();
      pc_load = 1'b0;
      check("resume_req", 32'(mem_req), 32'd1);
      check("resume_addr", mem_addr, 32'h0000_0600);
      wait_idone("resume");
      check("resume_pc", ins_pc, 32'h0000_0600);

      // Address wrap at the top of the 32-bit space
      fill_idle();
      pc_load = 1'b1; pc_new = 32'hFFFF_FFFC; stall = 1'b0;
      tick();
      pc_load = 1'b0;
      check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
      wait_req_rise("wrap_next");
      check("wrap_next_addr", mem_addr, 32'h0000_0000);
      wait_idone("wrap");
      check("wrap_pc0", ins_pc, 32'hFFFF_FFFC);
      check("wrap_ins0", 32'(ins), 32'h0000_3C59);
      tick();
      check("wrap_idone1", 32'(idone), 32'd1);
      check("wrap_pc1", ins_pc, 32'hFFFF_FFFE);
      check("wrap_ins1", 32'(ins), 32'h0000_3C5B);

      repeat (20) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
